horizontal_in_process: RTL and testbench



---
 rtl/horizontal_pkg.sv | 41 ++++
 rtl/horizontal_dly_line.sv | 31 +++
 rtl/horizontal_in_process.sv | 191 +++++++++++++++++++
 tb/tb_horizontal_in_process.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/horizontal_pkg.sv
// Shared definitions for the horizontal R16 stage: bank select codes, frame
// phase boundaries and the phase decode used by both the writer and the reader.
package horizontal_pkg;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_LO   = 2'd1;
  localparam logic [1:0] SEL_HI   = 2'd2;

  localparam logic [3:0] PH_A_END   = 4'd3;
  localparam logic [3:0] PH_B_MID   = 4'd7;
  localparam logic [3:0] PH_B_END   = 4'd11;
  localparam logic [3:0] FRAME_LAST = 4'd15;

  // Four quarter-frames: even banks high half, odd low, odd high, even low.
  typedef enum logic [1:0] {
    PH_EVEN_HI = 2'd0,
    PH_ODD_LO  = 2'd1,
    PH_ODD_HI  = 2'd2,
    PH_EVEN_LO = 2'd3
  } phase_e;

  typedef struct packed {
    logic       en;
    logic [3:0] cnt;
  } slot_t;

  function automatic phase_e phase_of(input logic [3:0] cnt);
    phase_e ph;
    if (cnt <= PH_A_END) begin
      ph = PH_EVEN_HI;
    end else if (cnt <= PH_B_MID) begin
      ph = PH_ODD_LO;
    end else if (cnt <= PH_B_END) begin
      ph = PH_ODD_HI;
    end else begin
      ph = PH_EVEN_LO;
    end
    return ph;
  endfunction

endpackage

// File: rtl/horizontal_dly_line.sv
// Generic WIDTH x DEPTH shift register; every stage clears on reset so no
// stale slot can emerge after a reset.
module horizontal_dly_line #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // shift din through DEPTH stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/horizontal_in_process.sv
// Horizontal input stage: issues ROM bank selects on the 16-slot schedule and
// steers returned words to four multiplier lanes. Optional: HORIZONTAL_IN_ABORT_EN.
module horizontal_in_process
  import horizontal_pkg::*;
#(
  parameter int P_WIDTH = 64,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               horizontal_en_in,
  input  logic [P_WIDTH-1:0] ROM0_q,
  input  logic [P_WIDTH-1:0] ROM1_q,
  input  logic [P_WIDTH-1:0] ROM2_q,
  input  logic [P_WIDTH-1:0] ROM3_q,
  input  logic [P_WIDTH-1:0] ROM4_q,
  input  logic [P_WIDTH-1:0] ROM5_q,
  input  logic [P_WIDTH-1:0] ROM6_q,
  input  logic [P_WIDTH-1:0] ROM7_q,
  output logic               ROM0_r,
  output logic [1:0]         ROM1_r,
  output logic [1:0]         ROM2_r,
  output logic [1:0]         ROM3_r,
  output logic [1:0]         ROM4_r,
  output logic [1:0]         ROM5_r,
  output logic [1:0]         ROM6_r,
  output logic [1:0]         ROM7_r,
  output logic [P_WIDTH-1:0] horizontal_mul0_out,
  output logic [P_WIDTH-1:0] horizontal_mul1_out,
  output logic [P_WIDTH-1:0] horizontal_mul2_out,
  output logic [P_WIDTH-1:0] horizontal_mul3_out,
  output logic               horizontal_valid_out
`ifdef HORIZONTAL_IN_ABORT_EN
  ,
  output logic               horizontal_abort_out
`endif
);

  logic [CNT_W-1:0]   cnt_r;
  logic               run_s;
  logic               rom0_s;
  logic [1:0]         sel_s [1:7];
  slot_t              slot_in_s;
  slot_t              slot_d_s;
  logic [P_WIDTH-1:0] lane0_s;
  logic [P_WIDTH-1:0] lane1_s;
  logic [P_WIDTH-1:0] lane2_s;
  logic [P_WIDTH-1:0] lane3_s;

  // Selects are combinational; holding them off during reset keeps the banks quiet.
  assign run_s = horizontal_en_in & rst_n;

  // slot counter, restarts at 0 whenever enable drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (horizontal_en_in) begin
      cnt_r <= (cnt_r == FRAME_LAST) ? '0 : cnt_r + 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end

  // bank select decode from the current slot
  always_comb begin
    rom0_s = 1'b0;
    for (int b = 1; b < 8; b++) begin
      sel_s[b] = SEL_NONE;
    end
    if (run_s) begin
      case (phase_of(cnt_r))
        PH_EVEN_HI: begin
          rom0_s   = 1'b1;
          sel_s[2] = SEL_HI;
          sel_s[4] = SEL_HI;
          sel_s[6] = SEL_HI;
        end
        PH_ODD_LO: begin
          sel_s[1] = SEL_LO;
          sel_s[3] = SEL_LO;
          sel_s[5] = SEL_LO;
          sel_s[7] = SEL_LO;
        end
        PH_ODD_HI: begin
          sel_s[1] = SEL_HI;
          sel_s[3] = SEL_HI;
          sel_s[5] = SEL_HI;
          sel_s[7] = SEL_HI;
        end
        PH_EVEN_LO: begin
          sel_s[2] = SEL_LO;
          sel_s[4] = SEL_LO;
          sel_s[6] = SEL_LO;
        end
        default: begin
          rom0_s = 1'b0;
        end
      endcase
    end else begin
      rom0_s = 1'b0;
    end
  end

  assign ROM0_r = rom0_s;
  assign ROM1_r = sel_s[1];
  assign ROM2_r = sel_s[2];
  assign ROM3_r = sel_s[3];
  assign ROM4_r = sel_s[4];
  assign ROM5_r = sel_s[5];
  assign ROM6_r = sel_s[6];
  assign ROM7_r = sel_s[7];

  assign slot_in_s.en  = horizontal_en_in;
  assign slot_in_s.cnt = cnt_r;

  horizontal_dly_line #(
    .WIDTH ($bits(slot_t)),
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (slot_in_s),
    .dout  (slot_d_s)
  );

  // lane steering for the slot whose bank data is arriving now
  always_comb begin
    lane0_s = '0;
    lane1_s = '0;
    lane2_s = '0;
    lane3_s = '0;
    if (slot_d_s.en) begin
      case (phase_of(slot_d_s.cnt))
        PH_EVEN_HI: begin
          lane0_s = ROM0_q;
          lane1_s = ROM2_q;
          lane2_s = ROM4_q;
          lane3_s = ROM6_q;
        end
        PH_ODD_LO, PH_ODD_HI: begin
          lane0_s = ROM1_q;
          lane1_s = ROM3_q;
          lane2_s = ROM5_q;
          lane3_s = ROM7_q;
        end
        PH_EVEN_LO: begin
          // lane 3 has no stored source in the last quarter
          lane0_s = ROM2_q;
          lane1_s = ROM4_q;
          lane2_s = ROM6_q;
          lane3_s = '0;
        end
        default: begin
          lane0_s = '0;
        end
      endcase
    end else begin
      lane0_s = '0;
    end
  end

  // registered lane outputs and valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      horizontal_mul0_out  <= '0;
      horizontal_mul1_out  <= '0;
      horizontal_mul2_out  <= '0;
      horizontal_mul3_out  <= '0;
      horizontal_valid_out <= 1'b0;
    end else begin
      horizontal_mul0_out  <= lane0_s;
      horizontal_mul1_out  <= lane1_s;
      horizontal_mul2_out  <= lane2_s;
      horizontal_mul3_out  <= lane3_s;
      horizontal_valid_out <= slot_d_s.en;
    end
  end

`ifdef HORIZONTAL_IN_ABORT_EN
  // flag a frame cut short: enable seen low while mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      horizontal_abort_out <= 1'b0;
    end else begin
      horizontal_abort_out <= !horizontal_en_in && (cnt_r != '0);
    end
  end
`endif

endmodule

// File: tb/tb_horizontal_in_process.sv
// Directed bench for horizontal_in_process: RD_LAT=1 and RD_LAT=3 instances
// run side by side against a bank model returning {bank, issue cycle}.
module tb_horizontal_in_process;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic        ff;
  logic [63:0] q1 [8];
  logic [63:0] q3 [8];
  logic        r1_0, r3_0;
  logic [1:0]  s1 [1:7];
  logic [1:0]  s3 [1:7];
  logic [63:0] m1 [4];
  logic [63:0] m3 [4];
  logic        v1, v3;
  logic        a1, a3;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          valid_from = 0;
  logic [3:0]  mcnt = 4'd0;
  logic        h_en  [0:511];
  logic [3:0]  h_cnt [0:511];

  horizontal_in_process #(.P_WIDTH(64), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .horizontal_en_in(en),
    .ROM0_q(q1[0]), .ROM1_q(q1[1]), .ROM2_q(q1[2]), .ROM3_q(q1[3]),
    .ROM4_q(q1[4]), .ROM5_q(q1[5]), .ROM6_q(q1[6]), .ROM7_q(q1[7]),
    .ROM0_r(r1_0), .ROM1_r(s1[1]), .ROM2_r(s1[2]), .ROM3_r(s1[3]),
    .ROM4_r(s1[4]), .ROM5_r(s1[5]), .ROM6_r(s1[6]), .ROM7_r(s1[7]),
    .horizontal_mul0_out(m1[0]), .horizontal_mul1_out(m1[1]),
    .horizontal_mul2_out(m1[2]), .horizontal_mul3_out(m1[3]),
    .horizontal_valid_out(v1)
`ifdef HORIZONTAL_IN_ABORT_EN
    , .horizontal_abort_out(a1)
`endif
  );

  horizontal_in_process #(.P_WIDTH(64), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .horizontal_en_in(en),
    .ROM0_q(q3[0]), .ROM1_q(q3[1]), .ROM2_q(q3[2]), .ROM3_q(q3[3]),
    .ROM4_q(q3[4]), .ROM5_q(q3[5]), .ROM6_q(q3[6]), .ROM7_q(q3[7]),
    .ROM0_r(r3_0), .ROM1_r(s3[1]), .ROM2_r(s3[2]), .ROM3_r(s3[3]),
    .ROM4_r(s3[4]), .ROM5_r(s3[5]), .ROM6_r(s3[6]), .ROM7_r(s3[7]),
    .horizontal_mul0_out(m3[0]), .horizontal_mul1_out(m3[1]),
    .horizontal_mul2_out(m3[2]), .horizontal_mul3_out(m3[3]),
    .horizontal_valid_out(v3)
`ifdef HORIZONTAL_IN_ABORT_EN
    , .horizontal_abort_out(a3)
`endif
  );

`ifndef HORIZONTAL_IN_ABORT_EN
  assign a1 = 1'b0;
  assign a3 = 1'b0;
`endif

  // Bank model: data seen L cycles after a cycle carries that cycle's number.
  logic [31:0] t1;
  logic [31:0] t3 [3];
  always @(posedge clk) begin
    t1    <= 32'(cyc);
    t3[0] <= 32'(cyc);
    t3[1] <= t3[0];
    t3[2] <= t3[1];
  end
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      q1[k] = ff ? {64{1'b1}} : {8'(k), 24'h0, t1};
      q3[k] = ff ? {64{1'b1}} : {8'(k), 24'h0, t3[2]};
    end
  end

  function automatic logic [14:0] exp_sel(input logic e, input logic [3:0] c);
    logic [1:0] s [8];
    for (int k = 0; k < 8; k++) s[k] = 2'd0;
    if (e) begin
      if (c <= 4'd3) begin
        s[0] = 2'd1; s[2] = 2'd2; s[4] = 2'd2; s[6] = 2'd2;
      end else if (c <= 4'd7) begin
        s[1] = 2'd1; s[3] = 2'd1; s[5] = 2'd1; s[7] = 2'd1;
      end else if (c <= 4'd11) begin
        s[1] = 2'd2; s[3] = 2'd2; s[5] = 2'd2; s[7] = 2'd2;
      end else begin
        s[2] = 2'd1; s[4] = 2'd1; s[6] = 2'd1;
      end
    end
    return {s[0][0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
  endfunction

  function automatic logic [63:0] word(input int b, input int tg);
    return {8'(b), 24'h0, 32'(tg)};
  endfunction

  // expected {valid, out0..out3} in cycle t for a read latency of L
  function automatic logic [256:0] exp_out(input int t, input int L);
    logic [256:0] r;
    int j;
    r = '0;
    j = t - L - 1;
    if (rst_n && j >= 0 && j >= valid_from && h_en[j]) begin
      if (h_cnt[j] <= 4'd3)       r = {1'b1, word(0, j), word(2, j), word(4, j), word(6, j)};
      else if (h_cnt[j] <= 4'd11) r = {1'b1, word(1, j), word(3, j), word(5, j), word(7, j)};
      else                        r = {1'b1, word(2, j), word(4, j), word(6, j), 64'h0};
    end
    return r;
  endfunction

  function automatic logic exp_abort(input int t);
`ifdef HORIZONTAL_IN_ABORT_EN
    int j;
    j = t - 1;
    return rst_n && j >= 0 && j >= valid_from && !h_en[j] && (h_cnt[j] != 4'd0);
`else
    return (t < 0);
`endif
  endfunction

  function automatic logic [545:0] exp_all();
    logic [14:0] es;
    logic        ea;
    es = exp_sel(en & rst_n, mcnt);
    ea = exp_abort(cyc);
    return {es, es, exp_out(cyc, 1), exp_out(cyc, 3), ea, ea};
  endfunction

  function automatic logic [545:0] got_all();
    return {r1_0, s1[1], s1[2], s1[3], s1[4], s1[5], s1[6], s1[7],
            r3_0, s3[1], s3[2], s3[3], s3[4], s3[5], s3[6], s3[7],
            v1, m1[0], m1[1], m1[2], m1[3],
            v3, m3[0], m3[1], m3[2], m3[3], a1, a3};
  endfunction

  task automatic step();
    h_en[cyc]  = en & rst_n;
    h_cnt[cyc] = mcnt;
    if (!rst_n) valid_from = cyc + 1;
    @(posedge clk);
    #1;
    mcnt = (rst_n && en) ? mcnt + 4'd1 : 4'd0;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; ff = 1'b1; mcnt = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      step();
    end
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      step();
    end
    ff = 1'b0;
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 22; i++) begin
      en = (i < 16);
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL single_frame cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    int maxrun = 0;
    for (int i = 0; i < 38; i++) begin
      en = (i < 32);
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      run = v1 ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      step();
    end
    if (maxrun !== 32) begin
      $display("FAIL back_to_back_valid_run got=%0d exp=32", maxrun);
      errors++;
    end
    checks++;
  endtask

  task automatic test_abort();
    int pulses = 0;
    for (int i = 0; i < 30; i++) begin
      en = (i != 7) && (i < 24);
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL abort_reenable cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      if (a1) pulses++;
      step();
    end
`ifdef HORIZONTAL_IN_ABORT_EN
    if (pulses !== 1) begin
      $display("FAIL abort_pulse_count got=%0d exp=1", pulses);
      errors++;
    end
    checks++;
`endif
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL async_pre cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      step();
    end
    rst_n = 1'b0;
    mcnt  = 4'd0;
    #1;
    if (got_all() !== exp_all()) begin
      $display("FAIL async_clear cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      errors++;
    end
    checks++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      en = (i < 16);
      #1;
      if (got_all() !== exp_all()) begin
        $display("FAIL async_restart cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
        errors++;
      end
      checks++;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    ff    = 1'b0;
    #3;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
